writeback: RTL and testbench
============================

Name: writeback

Overview:
- Writeback stage that produces the register-file write port (rf_wen, rf_rd, wbdata) consumed by the decode stage's register file.
- Selects the write data from one of three sources: ALU result, pc+4, or data-memory load.
- Loads run a multi-cycle memory handshake with byte/halfword extraction, sign/zero extension, a timeout, and a stall back to upstream.

Parameters:
- TIMEOUT, 16, max cycles spent in LOAD_WAIT without mem_rvalid before aborting (>=2).
- CNT_W, 5, timeout counter width; must hold TIMEOUT.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- wb_valid  in  1  instruction presented this cycle; accepted only when stall=0.
- wb_sel  in  2  write source: 00 ALU, 01 memory load, 10 pc+4, 11 none.
- rf_we_in  in  1  instruction writes rd.
- rd  in  5  destination register index.
- alu_out  in  32  ALU result; this is the byte address for loads.
- pc  in  32  instruction pc.
- funct3  in  3  load type: 0 lb, 1 lh, 2 lw, 4 lbu, 5 lhu.
- mem_req  out  1  load request, held high in LOAD_WAIT.
- mem_addr  out  32  word-aligned load address: {alu_out[31:2],2'b00}.
- mem_rvalid  in  1  memory read data valid.
- mem_rdata  in  32  memory read word.
- rf_wen  out  1  register-file write enable, 1-cycle pulse.
- rf_rd  out  5  register-file write index.
- wbdata  out  32  register-file write data.
- stall  out  1  high while a load is outstanding; upstream holds its inputs.
- err  out  1  1-cycle pulse on misaligned load, illegal funct3, or timeout.

Behaviour:
- Reset (reset=0, async):
  - state=IDLE, counter=0.
  - rf_wen=0, rf_rd=0, wbdata=0, mem_req=0, mem_addr=0, stall=0, err=0.
  - Reset asserted during LOAD_WAIT drops mem_req immediately; no write follows.
- States: IDLE, LOAD_WAIT.
- IDLE, wb_valid=1, wb_sel=00 or 10:
  - Next cycle: rf_wen=rf_we_in && rd!=0.
  - rf_rd=rd, wbdata=alu_out (00) or pc+4 (10), mod 2^32.
  - Latency 1 cycle; back-to-back accepts allowed every cycle.
- IDLE, wb_valid=1, wb_sel=11: no write; rf_wen=0 next cycle.
- IDLE, wb_valid=1, wb_sel=01 (load):
  - Check first: funct3 in {3,6,7}, or lh/lhu with alu_out[0]=1, or lw with alu_out[1:0]!=0.
  - If the check fails: err=1 next cycle, no mem_req, no write, stay IDLE.
  - Otherwise latch rd, rf_we_in, funct3 and alu_out[1:0]; next cycle mem_req=1, mem_addr valid, stall=1, counter=0; state goes to LOAD_WAIT.
- LOAD_WAIT:
  - Counter increments every cycle.
  - On mem_rvalid=1: extract the byte (offset a[1:0]) or halfword (a[1]) from mem_rdata, sign-extend for lb/lh, zero-extend for lbu/lhu, lw passes the word.
  - Next cycle: wbdata=result, rf_rd=latched rd, rf_wen=latched we && rd!=0, mem_req=0, stall=0, state=IDLE.
  - Load-to-write latency is 1 cycle after mem_rvalid.
  - If counter reaches TIMEOUT-1 with mem_rvalid=0: next cycle err=1, mem_req=0, stall=0, IDLE, no write.
  - mem_rvalid on that same final cycle wins over timeout: normal write, no err.
  - wb_valid is ignored while stall=1.
- mem_rvalid in IDLE is ignored.
- wbdata and rf_rd hold their last values when rf_wen=0.
- err is high only in the single cycle after the triggering event.

Test Plan:
- ALU write: wb_sel=00, rd=5, rf_we_in=1, alu_out=0x1234_5678 -> next cycle rf_wen=1, rf_rd=5, wbdata=0x12345678; following cycle rf_wen=0.
- pc+4 wrap and x0 suppression: wb_sel=10, pc=0xFFFF_FFFC -> wbdata=0x0; repeat with rd=0 -> rf_wen stays 0.
- Byte/half loads: mem_rdata=0x80FF_7F01.
  - lb @addr 0x103 -> wbdata=0xFFFF_FF80.
  - lbu @0x101 -> 0x0000_007F.
  - lh @0x102 -> 0xFFFF_80FF.
  - mem_addr=0x100 in every case; stall high until the cycle after mem_rvalid.
- Misaligned/illegal: lw @0x102, lh @0x101, funct3=3 -> each gives err pulse, mem_req never asserts, rf_wen=0.
- Timeout: TIMEOUT=16, load with mem_rvalid never asserted -> mem_req high 16 cycles, then err=1, stall=0, no write. Repeat with mem_rvalid on cycle 16 -> normal write, err=0.
- Async reset mid-load: drive reset=0 between clock edges during LOAD_WAIT -> mem_req and stall drop immediately. After release, the stale mem_rvalid is ignored and the next ALU op writes normally.

Source files
------------

// File: rtl/writeback.sv
`default_nettype none
// ============================================================================
// Module   : writeback
// Purpose  : Writeback stage that drives the register-file write port.
//            The write data comes from the ALU result, pc+4, or a data-memory
//            load. A load runs a request/valid handshake with the memory. The
//            returned word is reduced to a byte or halfword and then sign- or
//            zero-extended. A load that waits too long is aborted, and
//            upstream is stalled while a load is outstanding.
// Ports    : clk        - clock, all state updates on posedge
//            reset      - asynchronous active-low reset
//            wb_valid   - instruction presented (ignored while stall=1)
//            wb_sel     - 00 ALU, 01 load, 10 pc+4, 11 no write
//            rf_we_in   - instruction writes rd
//            rd         - destination register index
//            alu_out    - ALU result / load byte address
//            pc         - instruction pc
//            funct3     - load type (lb, lh, lw, lbu, lhu)
//            mem_req    - load request, high while waiting for data
//            mem_addr   - word-aligned load address
//            mem_rvalid - memory read data valid
//            mem_rdata  - memory read word
//            rf_wen     - register-file write enable (1-cycle pulse)
//            rf_rd      - register-file write index
//            wbdata     - register-file write data
//            stall      - load outstanding, upstream must hold
//            err        - 1-cycle pulse: misaligned/illegal load or timeout
// Revision : 1.0 - initial release
// ============================================================================
module writeback #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wb_valid,
  input  logic [1:0]  wb_sel,
  input  logic        rf_we_in,
  input  logic [4:0]  rd,
  input  logic [31:0] alu_out,
  input  logic [31:0] pc,
  input  logic [2:0]  funct3,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        rf_wen,
  output logic [4:0]  rf_rd,
  output logic [31:0] wbdata,
  output logic        stall,
  output logic        err
);

  typedef enum logic [0:0] {
    IDLE      = 1'b0,
    LOAD_WAIT = 1'b1
  } state_t;

  localparam logic [2:0] F3_LB  = 3'd0;
  localparam logic [2:0] F3_LH  = 3'd1;
  localparam logic [2:0] F3_LW  = 3'd2;
  localparam logic [2:0] F3_LBU = 3'd4;
  localparam logic [2:0] F3_LHU = 3'd5;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             rf_wen_nxt;
  logic [4:0]       rf_rd_nxt;
  logic [31:0]      wbdata_nxt;
  logic             err_nxt;
  logic [31:0]      mem_addr_nxt;

  // Load context captured when the load is accepted
  logic [4:0]       ld_rd, ld_rd_nxt;
  logic             ld_we, ld_we_nxt;
  logic [2:0]       ld_f3, ld_f3_nxt;
  logic [1:0]       ld_off, ld_off_nxt;

  logic             load_bad;
  logic [7:0]       rd_byte;
  logic [15:0]      rd_half;
  logic [31:0]      load_result;

  // Request and stall are pure functions of the state register, so an
  // asynchronous reset removes them immediately.
  assign mem_req = (state == LOAD_WAIT);
  assign stall   = (state == LOAD_WAIT);

  // Alignment / legality check on the incoming load
  always_comb begin
    load_bad = 1'b0;
    case (funct3)
      F3_LB, F3_LBU: load_bad = 1'b0;
      F3_LH, F3_LHU: load_bad = alu_out[0];
      F3_LW:         load_bad = (alu_out[1:0] != 2'b00);
      default:       load_bad = 1'b1;
    endcase
  end

  // Byte/halfword extraction from the returned word using the latched offset
  always_comb begin
    rd_byte = mem_rdata[7:0];
    case (ld_off)
      2'd0: rd_byte = mem_rdata[7:0];
      2'd1: rd_byte = mem_rdata[15:8];
      2'd2: rd_byte = mem_rdata[23:16];
      2'd3: rd_byte = mem_rdata[31:24];
      default: rd_byte = mem_rdata[7:0];
    endcase
    rd_half = ld_off[1] ? mem_rdata[31:16] : mem_rdata[15:0];

    load_result = mem_rdata;
    case (ld_f3)
      F3_LB:   load_result = {{24{rd_byte[7]}}, rd_byte};
      F3_LH:   load_result = {{16{rd_half[15]}}, rd_half};
      F3_LBU:  load_result = {24'd0, rd_byte};
      F3_LHU:  load_result = {16'd0, rd_half};
      default: load_result = mem_rdata;
    endcase
  end

  // Next-state and next-output logic
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    rf_wen_nxt   = 1'b0;
    rf_rd_nxt    = rf_rd;
    wbdata_nxt   = wbdata;
    err_nxt      = 1'b0;
    mem_addr_nxt = mem_addr;
    ld_rd_nxt    = ld_rd;
    ld_we_nxt    = ld_we;
    ld_f3_nxt    = ld_f3;
    ld_off_nxt   = ld_off;

    case (state)
      IDLE: begin
        if (wb_valid) begin
          case (wb_sel)
            2'b00, 2'b10: begin
              // rf_rd/wbdata only move when a write really happens
              if (rf_we_in && (rd != 5'd0)) begin
                rf_wen_nxt = 1'b1;
                rf_rd_nxt  = rd;
                wbdata_nxt = wb_sel[1] ? (pc + 32'd4) : alu_out;
              end
            end
            2'b01: begin
              if (load_bad) begin
                err_nxt = 1'b1;
              end else begin
                ld_rd_nxt    = rd;
                ld_we_nxt    = rf_we_in;
                ld_f3_nxt    = funct3;
                ld_off_nxt   = alu_out[1:0];
                mem_addr_nxt = {alu_out[31:2], 2'b00};
                cnt_nxt      = '0;
                state_nxt    = LOAD_WAIT;
              end
            end
            default: ;
          endcase
        end
      end

      LOAD_WAIT: begin
        cnt_nxt = cnt + CNT_W'(1);
        // Data arriving on the final allowed cycle beats the timeout
        if (mem_rvalid) begin
          state_nxt = IDLE;
          if (ld_we && (ld_rd != 5'd0)) begin
            rf_wen_nxt = 1'b1;
            rf_rd_nxt  = ld_rd;
            wbdata_nxt = load_result;
          end
        end else if (cnt == CNT_LAST) begin
          state_nxt = IDLE;
          err_nxt   = 1'b1;
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      cnt      <= '0;
      rf_wen   <= 1'b0;
      rf_rd    <= 5'd0;
      wbdata   <= 32'd0;
      err      <= 1'b0;
      mem_addr <= 32'd0;
      ld_rd    <= 5'd0;
      ld_we    <= 1'b0;
      ld_f3    <= 3'd0;
      ld_off   <= 2'd0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      rf_wen   <= rf_wen_nxt;
      rf_rd    <= rf_rd_nxt;
      wbdata   <= wbdata_nxt;
      err      <= err_nxt;
      mem_addr <= mem_addr_nxt;
      ld_rd    <= ld_rd_nxt;
      ld_we    <= ld_we_nxt;
      ld_f3    <= ld_f3_nxt;
      ld_off   <= ld_off_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_writeback.sv
`default_nettype none
// ============================================================================
// Module   : tb_writeback
// Purpose  : Self-checking bench for writeback. A transaction-level model
//            predicts every output each cycle, and directed sequences pin
//            hand-computed values.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_writeback;

  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        wb_valid = 1'b0;
  logic [1:0]  wb_sel = 2'd0;
  logic        rf_we_in = 1'b0;
  logic [4:0]  rd = 5'd0;
  logic [31:0] alu_out = 32'd0;
  logic [31:0] pc = 32'd0;
  logic [2:0]  funct3 = 3'd0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = 32'd0;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        rf_wen;
  logic [4:0]  rf_rd;
  logic [31:0] wbdata;
  logic        stall;
  logic        err;

  int n_pass = 0;
  int n_total = 0;
  bit chk_en = 1'b0;

  writeback #(.TIMEOUT(TIMEOUT), .CNT_W(5)) dut (
    .clk(clk), .reset(reset), .wb_valid(wb_valid), .wb_sel(wb_sel),
    .rf_we_in(rf_we_in), .rd(rd), .alu_out(alu_out), .pc(pc),
    .funct3(funct3), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .rf_wen(rf_wen),
    .rf_rd(rf_rd), .wbdata(wbdata), .stall(stall), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] load_value(input logic [2:0] f3, input logic [1:0] off,
                                             input logic [31:0] word);
    logic [31:0] b;
    logic [31:0] h;
    b = (word >> (8 * int'(off))) & 32'h0000_00FF;
    h = (word >> (16 * int'(off[1]))) & 32'h0000_FFFF;
    case (f3)
      3'd0:    return (b >= 32'd128)   ? b + 32'hFFFF_FF00 : b;
      3'd1:    return (h >= 32'd32768) ? h + 32'hFFFF_0000 : h;
      3'd4:    return b;
      3'd5:    return h;
      default: return word;
    endcase
  endfunction

  function automatic bit bad_load(input logic [2:0] f3, input logic [31:0] a);
    if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) return 1'b1;
    if ((f3 == 3'd1 || f3 == 3'd5) && (a % 2 != 0)) return 1'b1;
    if (f3 == 3'd2 && (a % 4 != 0)) return 1'b1;
    return 1'b0;
  endfunction

  bit          m_busy = 1'b0;
  int          m_wait = 0;
  logic [4:0]  m_ld_rd = 5'd0;
  bit          m_ld_we = 1'b0;
  logic [2:0]  m_ld_f3 = 3'd0;
  logic [1:0]  m_ld_off = 2'd0;
  logic        m_wen = 1'b0;
  logic [4:0]  m_rd = 5'd0;
  logic [31:0] m_data = 32'd0;
  logic        m_err = 1'b0;
  logic [31:0] m_addr = 32'd0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_busy <= 1'b0; m_wait <= 0; m_wen <= 1'b0; m_rd <= 5'd0;
      m_data <= 32'd0; m_err <= 1'b0; m_addr <= 32'd0;
    end else begin
      m_wen <= 1'b0;
      m_err <= 1'b0;
      if (m_busy) begin
        if (mem_rvalid) begin
          m_busy <= 1'b0;
          if (m_ld_we && m_ld_rd != 5'd0) begin
            m_wen  <= 1'b1;
            m_rd   <= m_ld_rd;
            m_data <= load_value(m_ld_f3, m_ld_off, mem_rdata);
          end
        end else if (m_wait == TIMEOUT - 1) begin
          m_busy <= 1'b0;
          m_err  <= 1'b1;
        end else begin
          m_wait <= m_wait + 1;
        end
      end else if (wb_valid) begin
        if (wb_sel == 2'd0 || wb_sel == 2'd2) begin
          if (rf_we_in && rd != 5'd0) begin
            m_wen  <= 1'b1;
            m_rd   <= rd;
            m_data <= (wb_sel == 2'd0) ? alu_out : pc + 32'd4;
          end
        end else if (wb_sel == 2'd1) begin
          if (bad_load(funct3, alu_out)) begin
            m_err <= 1'b1;
          end else begin
            m_busy   <= 1'b1;
            m_wait   <= 0;
            m_ld_rd  <= rd;
            m_ld_we  <= rf_we_in;
            m_ld_f3  <= funct3;
            m_ld_off <= alu_out[1:0];
            m_addr   <= alu_out - (alu_out % 4);
          end
        end
      end
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      check("rf_wen",   rf_wen,   m_wen);
      check("rf_rd",    rf_rd,    m_rd);
      check("wbdata",   wbdata,   m_data);
      check("err",      err,      m_err);
      check("mem_req",  mem_req,  m_busy);
      check("stall",    stall,    m_busy);
      check("mem_addr", mem_addr, m_addr);
    end
  end

  // ---------------- stimulus ----------------
  task automatic issue(input logic [1:0] sel, input logic we, input logic [4:0] r,
                       input logic [31:0] a, input logic [31:0] p, input logic [2:0] f3);
    @(posedge clk); #2;
    wb_valid = 1'b1; wb_sel = sel; rf_we_in = we; rd = r; alu_out = a; pc = p; funct3 = f3;
    @(posedge clk); #2;
    wb_valid = 1'b0;
  endtask

  // Load that gets its data on wait-cycle 'dly' (0 = first cycle in LOAD_WAIT)
  task automatic do_load(input string name, input logic [2:0] f3, input logic [31:0] a,
                         input int dly, input logic [31:0] word, input logic [31:0] exp);
    issue(2'd1, 1'b1, 5'd9, a, 32'd0, f3);
    @(negedge clk);
    check({name, "_req"},   mem_req,  32'd1);
    check({name, "_addr"},  mem_addr, 32'h0000_0100);
    check({name, "_stall"}, stall,    32'd1);
    repeat (dly) @(posedge clk);
    #2;
    mem_rvalid = 1'b1; mem_rdata = word;
    @(posedge clk); #2;
    mem_rvalid = 1'b0;
    @(negedge clk);
    check({name, "_wen"},   rf_wen, 32'd1);
    check({name, "_data"},  wbdata, exp);
    check({name, "_stall"}, stall,  32'd0);
    check({name, "_err"},   err,    32'd0);
  endtask

  task automatic bad(input string name, input logic [2:0] f3, input logic [31:0] a);
    issue(2'd1, 1'b1, 5'd4, a, 32'd0, f3);
    @(negedge clk);
    check({name, "_err"}, err,     32'd1);
    check({name, "_req"}, mem_req, 32'd0);
    check({name, "_wen"}, rf_wen,  32'd0);
    @(negedge clk);
    check({name, "_err2"}, err,    32'd0);
    check({name, "_req2"}, mem_req, 32'd0);
  endtask

  initial begin
    int req_cycles;
    repeat (2) @(negedge clk);
    check("rst_wen",    rf_wen,   32'd0);
    check("rst_wbdata", wbdata,   32'd0);
    check("rst_req",    mem_req,  32'd0);
    check("rst_addr",   mem_addr, 32'd0);
    check("rst_err",    err,      32'd0);
    @(posedge clk); #2;
    reset = 1'b1;
    chk_en = 1'b1;

    // ALU write, then the pulse ends
    issue(2'd0, 1'b1, 5'd5, 32'h1234_5678, 32'd0, 3'd0);
    @(negedge clk);
    check("alu_wen", rf_wen, 32'd1);
    check("alu_rd",  rf_rd,  32'd5);
    check("alu_data", wbdata, 32'h1234_5678);
    @(negedge clk);
    check("alu_wen_off", rf_wen, 32'd0);

    // pc+4 wraps; x0 write suppressed and data held
    issue(2'd2, 1'b1, 5'd7, 32'd0, 32'hFFFF_FFFC, 3'd0);
    @(negedge clk);
    check("pc4_wen",  rf_wen, 32'd1);
    check("pc4_data", wbdata, 32'd0);
    issue(2'd2, 1'b1, 5'd0, 32'd0, 32'h0000_0010, 3'd0);
    @(negedge clk);
    check("x0_wen",  rf_wen, 32'd0);
    check("x0_hold", wbdata, 32'd0);

    do_load("lb",  3'd0, 32'h0000_0103, 0, 32'h80FF_7F01, 32'hFFFF_FF80);
    do_load("lbu", 3'd4, 32'h0000_0101, 2, 32'h80FF_7F01, 32'h0000_007F);
    do_load("lh",  3'd1, 32'h0000_0102, 5, 32'h80FF_7F01, 32'hFFFF_80FF);

    bad("lw_mis", 3'd2, 32'h0000_0102);
    bad("lh_mis", 3'd1, 32'h0000_0101);
    bad("f3_3",   3'd3, 32'h0000_0100);

    // Timeout with no data
    issue(2'd1, 1'b1, 5'd6, 32'h0000_0200, 32'd0, 3'd2);
    req_cycles = 0;
    repeat (TIMEOUT) begin
      @(negedge clk);
      if (mem_req) req_cycles++;
    end
    check("to_req_cycles", req_cycles, TIMEOUT);
    @(negedge clk);
    check("to_err",   err,     32'd1);
    check("to_stall", stall,   32'd0);
    check("to_req",   mem_req, 32'd0);
    check("to_wen",   rf_wen,  32'd0);
    @(negedge clk);
    check("to_err_off", err, 32'd0);

    // Data on the final allowed cycle wins
    do_load("to_edge", 3'd2, 32'h0000_0100, TIMEOUT - 1, 32'h80FF_7F01, 32'h80FF_7F01);

    // Async reset in the middle of a load
    issue(2'd1, 1'b1, 5'd8, 32'h0000_0100, 32'd0, 3'd2);
    repeat (3) @(posedge clk);
    #3;
    reset = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    #1;
    check("arst_req",   mem_req, 32'd0);
    check("arst_stall", stall,   32'd0);
    @(posedge clk); #2;
    reset = 1'b1;
    @(posedge clk); #2;
    mem_rvalid = 1'b0;
    @(negedge clk);
    check("arst_nowrite", rf_wen, 32'd0);
    issue(2'd0, 1'b1, 5'd3, 32'hCAFE_BABE, 32'd0, 3'd0);
    @(negedge clk);
    check("arst_alu_wen",  rf_wen, 32'd1);
    check("arst_alu_data", wbdata, 32'hCAFE_BABE);

    // Randomized traffic, checked every cycle by the model
    repeat (3000) begin
      @(posedge clk); #2;
      wb_valid   = ($urandom_range(0, 3) != 0);
      wb_sel     = 2'($urandom);
      rf_we_in   = ($urandom_range(0, 3) != 0);
      rd         = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom);
      alu_out    = $urandom;
      if ($urandom_range(0, 1) == 1) alu_out[1:0] = 2'b00;
      pc         = $urandom;
      funct3     = 3'($urandom);
      mem_rvalid = ($urandom_range(0, 5) == 0);
      mem_rdata  = $urandom;
    end
    @(posedge clk); #2;
    wb_valid = 1'b0; mem_rvalid = 1'b0;
    repeat (TIMEOUT + 4) @(posedge clk);
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
